// File: rtl/dummy_bitmask_serializer.sv
// Bitmask serializer: accepts a request bitmask and emits the index of each set bit,
// lowest first, over a valid/ready stream, then returns to accept the next mask.

package cf_math_pkg;
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction
endpackage

// Leading/trailing zero counter; MODE=0 counts trailing zeros, MODE=1 leading zeros.
module lzc #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (MODE) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end else begin
        // Scan downwards so the lowest set bit is the final assignment.
        if (in_i[int'(WIDTH) - 1 - i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

module dummy_bitmask_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic             mask_valid_i,
  output logic             mask_ready_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic             last_o,
  output logic             empty_o,
  output logic [IDX_W:0]   cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] tz_idx;
  logic             pend_zero;
  logic             pend_onehot;
  logic             in_drain;
  logic             mask_hs;
  logic             idx_hs;

  lzc #(
    .WIDTH     (WIDTH),
    .MODE      (1'b0),
    .CNT_WIDTH (IDX_W)
  ) u_tz (
    .in_i    (pend_q),
    .cnt_o   (tz_idx),
    .empty_o (pend_zero)
  );

  assign in_drain    = (state_q == DRAIN);
  assign pend_onehot = ~pend_zero & ~|(pend_q & (pend_q - {{(WIDTH-1){1'b0}}, 1'b1}));

  assign mask_ready_o = ~in_drain;
  assign idx_valid_o  = in_drain;
  assign idx_o        = in_drain ? tz_idx : '0;
  assign last_o       = in_drain & pend_onehot;
  assign empty_o      = empty_q;
  assign cnt_o        = cnt_q;

  assign mask_hs = mask_valid_i & mask_ready_o;
  assign idx_hs  = idx_valid_o & idx_ready_i;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    empty_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mask_hs) begin
          pend_d  = mask_i;
          cnt_d   = '0;
          empty_d = ~|mask_i;
          if (|mask_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (idx_hs) begin
          pend_d = pend_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << tz_idx);
          cnt_d  = cnt_q + {{IDX_W{1'b0}}, 1'b1};
          if (last_o) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the pending mask is datapath, but it is reset with the control state so an
  // interrupted drain cannot leak stale indices into the next mask.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_dummy_bitmask_serializer.sv
// Directed bench for dummy_bitmask_serializer (WIDTH=8): vector table plus
// hand-written sequences for backpressure, mid-drain reset and held mask_valid.

module tb_dummy_bitmask_serializer;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic [W-1:0]  mask;
  logic          mask_valid;
  logic          mask_ready;
  logic [IW-1:0] idx;
  logic          idx_valid;
  logic          idx_ready;
  logic          last;
  logic          empty;
  logic [IW:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dummy_bitmask_serializer #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mask_i       (mask),
    .mask_valid_i (mask_valid),
    .mask_ready_o (mask_ready),
    .idx_o        (idx),
    .idx_valid_o  (idx_valid),
    .idx_ready_i  (idx_ready),
    .last_o       (last),
    .empty_o      (empty),
    .cnt_o        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name, input logic [IW:0] exp_cnt);
    check({name, " idx_valid"},  {31'd0, idx_valid},  32'd0);
    check({name, " idx"},        {29'd0, idx},        32'd0);
    check({name, " last"},       {31'd0, last},       32'd0);
    check({name, " mask_ready"}, {31'd0, mask_ready}, 32'd1);
    check({name, " cnt"},        {28'd0, cnt},        {28'd0, exp_cnt});
  endtask

  task automatic check_beat(input string name, input logic [IW-1:0] exp_idx, input logic exp_last);
    check({name, " idx_valid"},  {31'd0, idx_valid},  32'd1);
    check({name, " idx"},        {29'd0, idx},        {29'd0, exp_idx});
    check({name, " last"},       {31'd0, last},       {31'd0, exp_last});
    check({name, " mask_ready"}, {31'd0, mask_ready}, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] mask;
    int           n;       // expected number of indices
    logic [31:0]  seq;     // expected indices, nibble k = k-th index emitted
  } vec_t;

  vec_t vecs[6];

  // Called at a negedge with the DUT idle; returns at the negedge of the final check.
  task automatic run_vec(input vec_t v, input string name);
    check({name, " ready before"}, {31'd0, mask_ready}, 32'd1);
    mask       = v.mask;
    mask_valid = 1'b1;
    idx_ready  = 1'b1;
    @(posedge clk);
    #1 mask_valid = 1'b0;
    if (v.n == 0) begin
      @(negedge clk);
      check({name, " empty pulse"}, {31'd0, empty}, 32'd1);
      check_idle({name, " empty"}, '0);
      @(negedge clk);
      check({name, " empty drop"}, {31'd0, empty}, 32'd0);
      check_idle({name, " empty after"}, '0);
    end else begin
      for (int k = 0; k < v.n; k++) begin
        logic [31:0] nib;
        @(negedge clk);
        nib = (v.seq >> (4 * k)) & 32'hF;
        check_beat($sformatf("%s beat%0d", name, k), nib[IW-1:0], k == v.n - 1);
        check($sformatf("%s beat%0d empty", name, k), {31'd0, empty}, 32'd0);
      end
      @(negedge clk);
      check_idle({name, " done"}, (IW+1)'(v.n));
    end
  endtask

  initial begin
    vecs[0] = '{mask: 8'hA4, n: 3, seq: 32'h0000_0752};
    vecs[1] = '{mask: 8'h00, n: 0, seq: 32'h0};
    vecs[2] = '{mask: 8'hFF, n: 8, seq: 32'h7654_3210};
    vecs[3] = '{mask: 8'h01, n: 1, seq: 32'h0};
    vecs[4] = '{mask: 8'h80, n: 1, seq: 32'h7};
    vecs[5] = '{mask: 8'h5A, n: 4, seq: 32'h0000_6431};

    rst        = 1'b1;
    mask       = '0;
    mask_valid = 1'b0;
    idx_ready  = 1'b0;
    #1;
    check_idle("reset", '0);
    check("reset empty", {31'd0, empty}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First mask is presented in the same cycle reset is released.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: 8'h12 with idx_ready held low for three cycles.
    mask = 8'h12; mask_valid = 1'b1; idx_ready = 1'b0;
    @(posedge clk);
    #1 mask_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_beat($sformatf("stall%0d", k), 3'd1, 1'b0);
      check($sformatf("stall%0d cnt", k), {28'd0, cnt}, 32'd0);
    end
    idx_ready = 1'b1;
    @(negedge clk);
    check_beat("stall next", 3'd4, 1'b1);
    check("stall next cnt", {28'd0, cnt}, 32'd1);
    @(negedge clk);
    check_idle("stall done", 4'd2);

    // Reset in the middle of draining 8'h81.
    mask = 8'h81; mask_valid = 1'b1; idx_ready = 1'b1;
    @(posedge clk);
    #1 mask_valid = 1'b0;
    @(negedge clk);
    check_beat("rst beat0", 3'd0, 1'b0);
    @(negedge clk);
    check_beat("rst beat1", 3'd7, 1'b1);
    idx_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("rst asserted", '0);
    check("rst asserted empty", {31'd0, empty}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idx_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_idle($sformatf("rst released%0d", k), '0);
    end
    run_vec('{mask: 8'h08, n: 1, seq: 32'h3}, "after rst");

    // mask_valid held high with a new mask while draining 8'h0C.
    mask = 8'h0C; mask_valid = 1'b1; idx_ready = 1'b1;
    @(posedge clk);
    #1 mask = 8'h03;
    @(negedge clk);
    check_beat("hold beat0", 3'd2, 1'b0);
    @(negedge clk);
    check_beat("hold beat1", 3'd3, 1'b1);
    @(negedge clk);
    check_idle("hold idle", 4'd2);
    @(posedge clk);
    #1 mask_valid = 1'b0;
    @(negedge clk);
    check_beat("hold next0", 3'd0, 1'b0);
    check("hold next0 cnt", {28'd0, cnt}, 32'd0);
    @(negedge clk);
    check_beat("hold next1", 3'd1, 1'b1);
    @(negedge clk);
    check_idle("hold done", 4'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dummy_bitmask_serializer.md
DUMMY_BITMASK_SERIALIZER -- requirements
Module: dummy_bitmask_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning the input bitmask width (legal range 2..64).
REQ-002 SHALL provide derived parameter IDX_W, default cf_math_pkg::idx_width(WIDTH), meaning the index output width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mask_i  input  WIDTH  request bitmask to serialize.
REQ-006 SHALL have port mask_valid_i  input  1  mask_i is valid.
REQ-007 SHALL have port mask_ready_o  output  1  block accepts a mask this cycle.
REQ-008 SHALL have port idx_o  output  IDX_W  index of the current set bit.
REQ-009 SHALL have port idx_valid_o  output  1  idx_o is valid.
REQ-010 SHALL have port idx_ready_i  input  1  downstream consumes idx_o.
REQ-011 SHALL have port last_o  output  1  current idx_o is the final set bit of the mask.
REQ-012 SHALL have port empty_o  output  1  one-cycle pulse: an all-zero mask was accepted.
REQ-013 SHALL have port cnt_o  output  IDX_W+1  number of indices emitted for the current or most recent mask.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and DRAIN.
REQ-015 SHALL hold mask_ready_o=1 in IDLE and 0 in DRAIN; the block never overlaps masks.
REQ-016 SHALL define a mask handshake as mask_valid_i & mask_ready_o at a rising edge.
REQ-017 SHALL, on a mask handshake with mask_i != 0, load mask_i into a pending register, clear cnt_o to 0, and enter DRAIN.
REQ-018 SHALL, on a mask handshake with mask_i == 0, stay in IDLE, leave the pending register at 0, clear cnt_o to 0, and assert empty_o for exactly the next cycle.
REQ-019 SHALL drive idx_valid_o=1 in DRAIN and 0 in IDLE; first idx_valid_o is one cycle after the mask handshake (latency 1).
REQ-020 SHALL drive idx_o as the trailing-zero count of the pending register (lowest set bit first), computed with common_cells lzc in trailing mode.
REQ-021 SHALL assert last_o only in DRAIN when the pending register has exactly one bit set; otherwise 0.
REQ-022 SHALL define an index handshake as idx_valid_o & idx_ready_i; on it, clear bit idx_o of the pending register and increment cnt_o by 1.
REQ-023 SHALL, on an index handshake with last_o=1, return to IDLE; mask_ready_o becomes 1 in the following cycle.
REQ-024 SHALL hold idx_o, last_o and idx_valid_o stable while idx_valid_o=1 and idx_ready_i=0.
REQ-025 SHALL keep cnt_o unchanged in IDLE until the next mask handshake; cnt_o never exceeds WIDTH.
REQ-026 SHALL ignore mask_i and mask_valid_i while in DRAIN.
REQ-027 SHALL drive idx_o=0 and last_o=0 whenever idx_valid_o=0.

Reset
REQ-028 SHALL, while rst_i=1, immediately force state=IDLE, pending=0, cnt_o=0, empty_o=0, idx_valid_o=0, idx_o=0, last_o=0 and mask_ready_o=1.
REQ-029 SHALL, on reset asserted mid-DRAIN, discard all remaining indices; no idx_valid_o follows after release without a new mask handshake.
REQ-030 SHALL accept a mask on the first rising edge after rst_i deasserts.

Verification (WIDTH=8)
REQ-031 SHALL cover: mask_i=8'hA4, idx_ready_i=1 -> idx_o 2,5,7 on consecutive cycles, last_o only with 7, cnt_o=3, mask_ready_o=1 one cycle after idx 7.
REQ-032 SHALL cover: mask_i=8'h12, idx_ready_i held 0 for 3 cycles -> idx_o=1 stable for those cycles, then idx_o 1,4 and cnt_o=2.
REQ-033 SHALL cover: mask_i=8'h00 -> empty_o high exactly 1 cycle, idx_valid_o stays 0, cnt_o=0, mask_ready_o stays 1.
REQ-034 SHALL cover: mask_i=8'hFF -> idx_o 0..7 in order, last_o with 7 only, cnt_o=8.
REQ-035 SHALL cover: mask_i=8'h81 accepted, rst_i pulsed after idx 0 is emitted -> all outputs at reset values, no idx 7 emitted; next mask 8'h08 -> idx_o=3 with last_o=1.
REQ-036 SHALL cover: mask_valid_i held 1 with a new mask during DRAIN -> mask is not accepted until the cycle after the last index handshake.
